// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
//
// Purpose:
//   Data- and control-hazard unit for a 5-stage in-order pipeline. It keeps a
//   shadow copy of the destination info for the instructions in EX, MEM and WB.
//   From that copy and the instruction in ID it produces operand-forwarding
//   selects, load-use stalls and redirect flushes. It also counts stall and
//   flush cycles in saturating counters.
//
// Ports:
//   cpu_clk      in   1   clock, all state updates on rising edge
//   cpu_rst      in   1   asynchronous active-high reset
//   id_valid     in   1   ID stage holds a real instruction
//   id_rs1/rs2   in   5   ID source register indices
//   id_rf_re     in   2   read enables (bit0 = rs1 used, bit1 = rs2 used)
//   id_rd        in   5   ID destination register
//   id_rf_we     in   1   ID writes the register file
//   id_wb_sel    in   2   ID writeback select (2'b01 = load from DRAM)
//   ex_redirect  in   1   taken branch/JAL/JALR resolved in EX
//   stall_pc     out  1   hold the PC
//   stall_if_id  out  1   hold the IF/ID register
//   flush_if_id  out  1   bubble into IF/ID
//   flush_id_ex  out  1   bubble into ID/EX
//   fwd_rs1_sel  out  2   00 regfile, 01 EX, 10 MEM, 11 WB
//   fwd_rs2_sel  out  2   same encoding for rs2
//   stall_cnt    out  16  saturating count of stall_pc cycles
//   flush_cnt    out  16  saturating count of ex_redirect cycles
// -----------------------------------------------------------------------------
module hazard_scheduler (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [1:0]  id_rf_re,
   input  logic [4:0]  id_rd,
   input  logic        id_rf_we,
   input  logic [1:0]  id_wb_sel,
   input  logic        ex_redirect,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [1:0]  fwd_rs1_sel,
   output logic [1:0]  fwd_rs2_sel,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_WB  = 2'b11;
   localparam logic [1:0] WB_DRAM = 2'b01;

   // Shadow stage records
   logic [4:0]  r_ex_rd;
   logic        r_ex_we;
   logic        r_ex_ld;
   logic [4:0]  r_mem_rd;
   logic        r_mem_we;
   logic        r_mem_ld;
   logic [4:0]  r_wb_rd;
   logic        r_wb_we;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   // A stage only counts as a hazard source when it really writes a non-x0 register.
   logic        w_ex_src;
   logic        w_mem_src;
   logic        w_wb_src;
   logic [4:0]  w_rs [2];
   logic [1:0]  w_sel [2];
   logic [1:0]  w_lu_hit;
   logic        w_load_use;
   logic        w_ex_bubble;

   assign w_ex_src  = r_ex_we  && (r_ex_rd  != 5'd0);
   assign w_mem_src = r_mem_we && (r_mem_rd != 5'd0);
   assign w_wb_src  = r_wb_we  && (r_wb_rd  != 5'd0);

   assign w_rs[0] = id_rs1;
   assign w_rs[1] = id_rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         logic w_hit_ex;
         logic w_hit_mem;
         logic w_hit_wb;

         assign w_hit_ex  = w_ex_src  && (r_ex_rd  == w_rs[gi]);
         assign w_hit_mem = w_mem_src && (r_mem_rd == w_rs[gi]);
         assign w_hit_wb  = w_wb_src  && (r_wb_rd  == w_rs[gi]);

         // A load in EX has no data yet, so it is skipped here; the load-use
         // bubble moves it into MEM, where the MEM select takes over.
         assign w_sel[gi] = !id_rf_re[gi]           ? SEL_RF  :
                            (w_hit_ex && !r_ex_ld)  ? SEL_EX  :
                            w_hit_mem               ? SEL_MEM :
                            w_hit_wb                ? SEL_WB  :
                                                      SEL_RF;

         assign w_lu_hit[gi] = id_rf_re[gi] && w_hit_ex && r_ex_ld;
      end
   endgenerate

   assign fwd_rs1_sel = w_sel[0];
   assign fwd_rs2_sel = w_sel[1];

   assign w_load_use = id_valid && (|w_lu_hit);

   // A redirect squashes both younger stages and overrides any load-use stall.
   always_comb begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (ex_redirect) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (w_load_use) begin
         stall_pc    = 1'b1;
         stall_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end
   end

   assign w_ex_bubble = flush_id_ex || !id_valid;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_ex_rd  <= 5'd0;
         r_ex_we  <= 1'b0;
         r_ex_ld  <= 1'b0;
         r_mem_rd <= 5'd0;
         r_mem_we <= 1'b0;
         r_mem_ld <= 1'b0;
         r_wb_rd  <= 5'd0;
         r_wb_we  <= 1'b0;
      end else begin
         r_wb_rd  <= r_mem_rd;
         r_wb_we  <= r_mem_we;
         r_mem_rd <= r_ex_rd;
         r_mem_we <= r_ex_we;
         r_mem_ld <= r_ex_ld;
         if (w_ex_bubble) begin
            r_ex_rd <= 5'd0;
            r_ex_we <= 1'b0;
            r_ex_ld <= 1'b0;
         end else begin
            r_ex_rd <= id_rd;
            r_ex_we <= id_rf_we;
            r_ex_ld <= (id_wb_sel == WB_DRAM);
         end
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         if (stall_pc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (ex_redirect && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   // MEM's load flag is carried for completeness of the record; nothing downstream needs it.
   logic w_unused;
   assign w_unused = r_mem_ld;

endmodule

// File: tb/tb_hazard_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hazard_scheduler
//
// Purpose:
//   Directed bench for hazard_scheduler. Each step drives one ID instruction
//   on the falling edge. It then pushes the expected outputs to a scoreboard
//   queue, and pops and compares them 2 ns later, before the next rising edge.
//   Counter expectations come from a small saturating model that is advanced
//   from the expected stall and the driven redirect.
// -----------------------------------------------------------------------------
module tb_hazard_scheduler;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs1 = '0;
   logic [4:0]  id_rs2 = '0;
   logic [1:0]  id_rf_re = '0;
   logic [4:0]  id_rd = '0;
   logic        id_rf_we = 1'b0;
   logic [1:0]  id_wb_sel = '0;
   logic        ex_redirect = 1'b0;
   logic        stall_pc;
   logic        stall_if_id;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [1:0]  fwd_rs1_sel;
   logic [1:0]  fwd_rs2_sel;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   hazard_scheduler dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rf_re    (id_rf_re),
      .id_rd       (id_rd),
      .id_rf_we    (id_rf_we),
      .id_wb_sel   (id_wb_sel),
      .ex_redirect (ex_redirect),
      .stall_pc    (stall_pc),
      .stall_if_id (stall_if_id),
      .flush_if_id (flush_if_id),
      .flush_id_ex (flush_id_ex),
      .fwd_rs1_sel (fwd_rs1_sel),
      .fwd_rs2_sel (fwd_rs2_sel),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      string       tag;
      logic        spc;
      logic        sif;
      logic        fif;
      logic        fex;
      logic [1:0]  f1;
      logic [1:0]  f2;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] m_scnt = 16'd0;
   logic [15:0] m_fcnt = 16'd0;

   task automatic chk(input string tag, input string field, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] re, input logic [4:0] rd, input logic we,
                        input logic [1:0] wbs, input logic redir);
      @(negedge cpu_clk);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rf_re    = re;
      id_rd       = rd;
      id_rf_we    = we;
      id_wb_sel   = wbs;
      ex_redirect = redir;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic expect_out(input string tag, input logic spc, input logic sif,
                             input logic fif, input logic fex,
                             input logic [1:0] f1, input logic [1:0] f2);
      exp_t e;
      exp_t g;
      e.tag = tag; e.spc = spc; e.sif = sif; e.fif = fif; e.fex = fex;
      e.f1 = f1; e.f2 = f2; e.sc = m_scnt; e.fc = m_fcnt;
      sb.push_back(e);
      #2;
      g = sb.pop_front();
      chk(g.tag, "stall_pc",    {15'd0, stall_pc},    {15'd0, g.spc});
      chk(g.tag, "stall_if_id", {15'd0, stall_if_id}, {15'd0, g.sif});
      chk(g.tag, "flush_if_id", {15'd0, flush_if_id}, {15'd0, g.fif});
      chk(g.tag, "flush_id_ex", {15'd0, flush_id_ex}, {15'd0, g.fex});
      chk(g.tag, "fwd_rs1_sel", {14'd0, fwd_rs1_sel}, {14'd0, g.f1});
      chk(g.tag, "fwd_rs2_sel", {14'd0, fwd_rs2_sel}, {14'd0, g.f2});
      chk(g.tag, "stall_cnt",   stall_cnt,            g.sc);
      chk(g.tag, "flush_cnt",   flush_cnt,            g.fc);
      $display("[TB] %-14s spc=%b sif=%b fif=%b fex=%b f1=%b f2=%b scnt=%h fcnt=%h",
               g.tag, stall_pc, stall_if_id, flush_if_id, flush_id_ex,
               fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt);
      // Advance the counter model for the coming rising edge.
      if (!cpu_rst) begin
         if (spc && (m_scnt != 16'hFFFF)) m_scnt = m_scnt + 16'd1;
         if (ex_redirect && (m_fcnt != 16'hFFFF)) m_fcnt = m_fcnt + 16'd1;
      end
   endtask

   initial begin
      int t;
      // Reset state, before and after a clock edge under reset
      @(negedge cpu_clk);
      expect_out("reset0", 0, 0, 0, 0, 2'b00, 2'b00);
      idle();
      expect_out("reset1", 0, 0, 0, 0, 2'b00, 2'b00);
      idle();
      cpu_rst = 1'b0;

      // Forwarding walk: EX -> MEM -> WB -> regfile
      drive(1, 5'd0, 5'd0, 2'b01, 5'd5, 1, 2'b00, 0);
      expect_out("fwd_add_x5", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd5, 5'd0, 2'b01, 5'd7, 1, 2'b00, 0);
      expect_out("fwd_ex", 0, 0, 0, 0, 2'b01, 2'b00);
      drive(1, 5'd5, 5'd0, 2'b01, 5'd0, 0, 2'b00, 0);
      expect_out("fwd_mem", 0, 0, 0, 0, 2'b10, 2'b00);
      drive(1, 5'd5, 5'd0, 2'b01, 5'd0, 0, 2'b00, 0);
      expect_out("fwd_wb", 0, 0, 0, 0, 2'b11, 2'b00);
      drive(1, 5'd5, 5'd0, 2'b01, 5'd0, 0, 2'b00, 0);
      expect_out("fwd_rf", 0, 0, 0, 0, 2'b00, 2'b00);
      repeat (3) idle();

      // Load-use on rs2: one stall cycle, then MEM forwarding
      drive(1, 5'd0, 5'd0, 2'b00, 5'd6, 1, 2'b01, 0);
      expect_out("lu_lw_x6", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd0, 5'd6, 2'b10, 5'd8, 1, 2'b00, 0);
      expect_out("lu_stall", 1, 1, 0, 1, 2'b00, 2'b00);
      drive(1, 5'd0, 5'd6, 2'b10, 5'd8, 1, 2'b00, 0);
      expect_out("lu_after", 0, 0, 0, 0, 2'b00, 2'b10);
      repeat (3) idle();

      // x3 in EX, MEM and WB; read enables gate the selects
      drive(1, 5'd3, 5'd3, 2'b00, 5'd3, 1, 2'b00, 0);
      expect_out("prio_fill1", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd3, 5'd3, 2'b00, 5'd3, 1, 2'b00, 0);
      expect_out("prio_nore1", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd3, 5'd3, 2'b00, 5'd3, 1, 2'b00, 0);
      expect_out("prio_nore2", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd3, 5'd3, 2'b01, 5'd0, 0, 2'b00, 0);
      expect_out("prio_ex", 0, 0, 0, 0, 2'b01, 2'b00);
      drive(1, 5'd3, 5'd3, 2'b10, 5'd0, 0, 2'b00, 0);
      expect_out("prio_mem", 0, 0, 0, 0, 2'b00, 2'b10);
      repeat (3) idle();

      // Load writing x0 never forwards or stalls
      drive(1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 2'b01, 0);
      expect_out("x0_load", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd0, 5'd0, 2'b11, 5'd0, 0, 2'b00, 0);
      expect_out("x0_read", 0, 0, 0, 0, 2'b00, 2'b00);
      repeat (3) idle();

      // Load-use and redirect together: redirect wins
      drive(1, 5'd0, 5'd0, 2'b00, 5'd9, 1, 2'b01, 0);
      expect_out("rd_lw_x9", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd9, 5'd0, 2'b01, 5'd4, 1, 2'b00, 1);
      expect_out("rd_and_lu", 0, 0, 1, 1, 2'b00, 2'b00);
      idle();
      expect_out("rd_after", 0, 0, 0, 0, 2'b00, 2'b00);

      // Flush counter saturation
      drive(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 2'b00, 1);
      repeat (65540) @(posedge cpu_clk);
      t = int'(m_fcnt) + 65540;
      m_fcnt = (t > 65535) ? 16'hFFFF : 16'(t);
      idle();
      expect_out("sat_flush", 0, 0, 0, 0, 2'b00, 2'b00);

      // Async reset in the middle of a load-use stall
      drive(1, 5'd0, 5'd0, 2'b00, 5'd10, 1, 2'b01, 0);
      expect_out("rst_lw_x10", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd10, 5'd0, 2'b01, 5'd11, 1, 2'b00, 0);
      expect_out("rst_stall", 1, 1, 0, 1, 2'b00, 2'b00);
      cpu_rst = 1'b1;
      m_scnt  = 16'd0;
      m_fcnt  = 16'd0;
      expect_out("rst_async", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd10, 5'd0, 2'b01, 5'd11, 1, 2'b00, 0);
      expect_out("rst_held", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd10, 5'd0, 2'b01, 5'd11, 1, 2'b00, 0);
      cpu_rst = 1'b0;
      expect_out("rst_release", 0, 0, 0, 0, 2'b00, 2'b00);
      drive(1, 5'd11, 5'd0, 2'b01, 5'd0, 0, 2'b00, 0);
      expect_out("rst_resume", 0, 0, 0, 0, 2'b01, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
